// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared core constants and writeback request type
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback source, issue and register-file signals
// Groups the ALU and load handshakes, the issue-side scoreboard set, the
// pending vector and the register-file write port.
//   master: drives valids/rd/data/issue, observes readies, pending and write port
//   slave : the arbiter; drives readies, pending, write_select and write
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [NUM_REGS-1:0]   pending;
  logic [REG_ADDR_W-1:0] write_select;
  logic [XLEN-1:0]       write;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd,
    input  alu_ready, mem_ready, pending, write_select, write
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd,
    output alu_ready, mem_ready, pending, write_select, write
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// rtl/regfile_wb_arbiter_wb_scoreboard.sv - pending-write scoreboard for RAW stalls
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   set_valid  : an instruction with a destination issues this cycle
//   set_idx    : its destination register
//   clr_idx    : register committing at this edge (0 = none)
//   pending    : one bit per register with an outstanding write; bit 0 is always 0
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]   pending
);

  // x0 has no storage; the loop starts at 1 so index 0 never matches.
  logic [NUM_REGS-1:1] pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        // A new producer issuing on the commit edge keeps the bit set.
        if (set_valid && set_idx == REG_ADDR_W'(i))
          pend_q[i] <= 1'b1;
        else if (clr_idx == REG_ADDR_W'(i))
          pend_q[i] <= 1'b0;
      end
    end
  end

  assign pending = {pend_q, 1'b0};

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source writeback arbiter for the register-file write port
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of regfile_wb_arbiter_if (ALU/load handshakes, issue,
//              pending vector, write_select/write to the register file)
// Parameters:
//   STARVE_LIMIT : refused-while-valid cycles after which the ALU beats the load path (1..15)
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  logic [3:0] starve_cnt;
  logic       starve_hit;
  logic       alu_grant;
  logic       mem_grant;
  wb_req_t    out_q;

  assign starve_hit = (starve_cnt >= 4'(STARVE_LIMIT));

  // Loads win by default; a starved ALU wins once. Readies are gated by
  // their own valid so the two can never be high together.
  assign bus.alu_ready = !rst && bus.alu_valid && (!bus.mem_valid || starve_hit);
  assign bus.mem_ready = !rst && bus.mem_valid && !(bus.alu_valid && starve_hit);

  assign alu_grant = bus.alu_valid && bus.alu_ready;
  assign mem_grant = bus.mem_valid && bus.mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus.alu_valid || alu_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Output register: rd=0 naturally yields write_select=0 (no write).
  // With no grant the data is held and only the select drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (alu_grant) begin
      out_q <= '{rd: bus.alu_rd, data: bus.alu_data};
    end else if (mem_grant) begin
      out_q <= '{rd: bus.mem_rd, data: bus.mem_data};
    end else begin
      out_q.rd <= '0;
    end
  end

  assign bus.write_select = out_q.rd;
  assign bus.write        = out_q.data;

  // The register file commits write_select at the next edge, which is
  // exactly when the scoreboard clears it.
  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (bus.issue_valid),
    .set_idx   (bus.issue_rd),
    .clr_idx   (out_q.rd),
    .pending   (bus.pending)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic leak_seen = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus_if ();

  regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Any register-file write carrying the reset-dropped load value is a leak.
  always @(negedge clk)
    if (!rst && bus_if.write_select == 5'd12 && bus_if.write == 32'h0000_1234)
      leak_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready(input string tag, input logic exp_alu, input logic exp_mem);
    chk({tag, "_alu_ready"}, {31'd0, bus_if.alu_ready}, {31'd0, exp_alu});
    chk({tag, "_mem_ready"}, {31'd0, bus_if.mem_ready}, {31'd0, exp_mem});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.alu_valid   = 1'b0;
    bus_if.alu_rd      = '0;
    bus_if.alu_data    = '0;
    bus_if.mem_valid   = 1'b0;
    bus_if.mem_rd      = '0;
    bus_if.mem_data    = '0;
    bus_if.issue_valid = 1'b0;
    bus_if.issue_rd    = '0;
  endtask

  initial begin
    logic [4:0] exp_ws [4];
    exp_ws[0] = 5'd4; exp_ws[1] = 5'd4; exp_ws[2] = 5'd4; exp_ws[3] = 5'd3;

    // Reset: readies held low even with both sources valid.
    idle();
    rst = 1'b1;
    bus_if.alu_valid = 1'b1;
    bus_if.mem_valid = 1'b1;
    #1;
    chk_ready("reset", 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_ws", {27'd0, bus_if.write_select}, 32'd0);
    chk("reset_write", bus_if.write, 32'd0);
    chk("reset_pending", bus_if.pending, 32'd0);
    chk("reset_starve", {28'd0, dut.starve_cnt}, 32'd0);

    // 1: ALU alone, one cycle.
    rst = 1'b0;
    idle();
    tick();
    bus_if.alu_valid = 1'b1;
    bus_if.alu_rd    = 5'd5;
    bus_if.alu_data  = 32'hDEAD_BEEF;
    #1;
    chk_ready("alu_only", 1'b1, 1'b0);
    tick();
    chk("alu_only_ws", {27'd0, bus_if.write_select}, 32'd5);
    chk("alu_only_write", bus_if.write, 32'hDEAD_BEEF);
    idle();
    tick();
    chk("alu_only_ws_drop", {27'd0, bus_if.write_select}, 32'd0);
    chk("alu_only_write_hold", bus_if.write, 32'hDEAD_BEEF);

    // 2: contention, mem x3 then alu.
    bus_if.alu_valid = 1'b1; bus_if.alu_rd = 5'd3; bus_if.alu_data = 32'h0000_0033;
    bus_if.mem_valid = 1'b1; bus_if.mem_rd = 5'd4; bus_if.mem_data = 32'h0000_0044;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_ready($sformatf("contend%0d", k), (k == 3), (k != 3));
      tick();
      chk($sformatf("contend%0d_ws", k), {27'd0, bus_if.write_select}, {27'd0, exp_ws[k]});
    end
    chk("contend_starve_reset", {28'd0, dut.starve_cnt}, 32'd0);
    chk("contend_write_alu", bus_if.write, 32'h0000_0033);
    #1;
    chk_ready("contend_after", 1'b0, 1'b1);
    idle();
    tick();
    tick();

    // 3: scoreboard set then clear on commit.
    bus_if.issue_valid = 1'b1; bus_if.issue_rd = 5'd7;
    tick();
    chk("sb_set", bus_if.pending, 32'h0000_0080);
    idle();
    tick();
    bus_if.mem_valid = 1'b1; bus_if.mem_rd = 5'd7; bus_if.mem_data = 32'h0000_0077;
    #1;
    chk_ready("sb_mem", 1'b0, 1'b1);
    tick();
    chk("sb_ws", {27'd0, bus_if.write_select}, 32'd7);
    chk("sb_still_pending", bus_if.pending, 32'h0000_0080);
    idle();
    tick();
    chk("sb_cleared", bus_if.pending, 32'd0);

    // 4: set and clear of the same register on one edge.
    bus_if.issue_valid = 1'b1; bus_if.issue_rd = 5'd9;
    tick();
    chk("sim_set", bus_if.pending, 32'h0000_0200);
    idle();
    bus_if.mem_valid = 1'b1; bus_if.mem_rd = 5'd9; bus_if.mem_data = 32'h0000_0099;
    tick();
    chk("sim_ws", {27'd0, bus_if.write_select}, 32'd9);
    idle();
    bus_if.issue_valid = 1'b1; bus_if.issue_rd = 5'd9;
    tick();
    chk("sim_set_wins", bus_if.pending, 32'h0000_0200);
    idle();
    bus_if.mem_valid = 1'b1; bus_if.mem_rd = 5'd9; bus_if.mem_data = 32'h0000_0999;
    tick();
    idle();
    tick();
    chk("sim_second_clear", bus_if.pending, 32'd0);

    // 5: register zero.
    bus_if.issue_valid = 1'b1; bus_if.issue_rd = 5'd0;
    tick();
    chk("zero_issue", bus_if.pending, 32'd0);
    idle();
    bus_if.alu_valid = 1'b1; bus_if.alu_rd = 5'd0; bus_if.alu_data = 32'h0000_0055;
    #1;
    chk_ready("zero_alu", 1'b1, 1'b0);
    tick();
    chk("zero_ws", {27'd0, bus_if.write_select}, 32'd0);
    idle();

    // 6: reset while a load is valid.
    bus_if.issue_valid = 1'b1; bus_if.issue_rd = 5'd12;
    tick();
    chk("rst_mid_pending_pre", bus_if.pending, 32'h0000_1000);
    idle();
    rst = 1'b1;
    bus_if.mem_valid = 1'b1; bus_if.mem_rd = 5'd12; bus_if.mem_data = 32'h0000_1234;
    #1;
    chk_ready("rst_mid", 1'b0, 1'b0);
    tick();
    chk("rst_mid_ws", {27'd0, bus_if.write_select}, 32'd0);
    chk("rst_mid_pending", bus_if.pending, 32'd0);
    rst = 1'b0;
    idle();
    tick();
    chk("rst_mid_ws_after", {27'd0, bus_if.write_select}, 32'd0);
    chk("rst_mid_write_after", bus_if.write, 32'd0);
    tick();
    chk("rst_mid_no_leak", {31'd0, leak_seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback sources: the ALU result path and the load (memory) return path.
- Each source uses a valid/ready handshake.
- The block registers the winning write, then drives write_select/write into the register file.
- It also keeps a pending-write scoreboard of issued-but-unwritten destination registers, so issue logic can stall on RAW hazards.

Parameters:
STARVE_LIMIT, 3, consecutive cycles the ALU may be valid-but-refused before it gets priority over the load path (legal range 1..15).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
alu_valid  input  1  ALU has a result to write back
alu_ready  output  1  ALU result accepted this cycle
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
mem_valid  input  1  load unit has a result to write back
mem_ready  output  1  load result accepted this cycle
mem_rd  input  5  load destination register
mem_data  input  32  load result
issue_valid  input  1  an instruction with a destination is issuing this cycle
issue_rd  input  5  destination of the issuing instruction
pending  output  32  pending[i]=1: register i has an outstanding write; bit 0 is always 0
write_select  output  5  to register file write_select; 0 = no write
write  output  32  to register file write data

Behaviour:
Reset (rst=1 at a rising edge):
- write_select=0, write=0, pending=0, starvation counter=0.
- alu_ready and mem_ready are 0 while rst=1.
- Reset mid-operation drops any accepted-but-uncommitted write; the register file sees write_select=0 the cycle after reset.

Handshake:
- A transfer occurs when valid && ready in the same cycle.
- ready is combinational from the valids and the arbitration state.
- ready does not depend on the source's own data.
- At most one source is granted per cycle.
- The output register is always free, so a sole requester is always granted.

Arbitration:
- Default priority is mem over alu.
- starve_cnt, 4 bits:
  - increments when alu_valid=1 and alu is not granted;
  - resets to 0 when alu is granted or alu_valid=0.
- When starve_cnt >= STARVE_LIMIT and both sources are valid, alu wins that cycle.

Output stage (one cycle latency):
- On a grant at edge N, write_select/write take {rd, data} of the winner after edge N.
- The register file commits the write at edge N+1.
- With no grant, write_select becomes 0 and write holds its previous value.
- A granted request with rd=0 is accepted (ready=1) and produces write_select=0, i.e. no write.

Scoreboard, evaluated at each rising edge:
- set: issue_valid && issue_rd!=0 sets pending[issue_rd].
- clear: a nonzero write_select clears pending[write_select]; this is the edge at which the register file commits.
- Simultaneous set and clear of the same index: set wins, because a new producer has issued.
- Issue to a register that is already pending leaves the bit at 1. The bit clears on the first subsequent commit to that register. Issue logic must not issue a second writer to a pending register.
- pending[0] is hardwired to 0.

Invariants:
- alu_ready && mem_ready is never 1.
- write_select only ever carries an rd that was handshaken in the previous cycle.

Decomposition:
- Shared package (the core's common package):
  - REG_ADDR_W=5
  - XLEN=32
  - NUM_REGS=32
  - a wb_req struct {rd, data}
- Sub-module wb_scoreboard holds the 32-bit pending vector with its set/clear/priority rules.
- Arbiter, starvation counter and output register stay in the top block.

Test Plan:
1. Reset, then alu only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle.
   - alu_ready=1 that cycle.
   - Next cycle write_select=5, write=0xDEADBEEF.
   - Following cycle write_select=0.
2. Contention: alu (rd=3) and mem (rd=4) both valid continuously, STARVE_LIMIT=3.
   - Grants go mem, mem, mem, then alu on the 4th cycle.
   - starve_cnt returns to 0 after the alu grant.
   - write_select sequence is 4,4,4,3.
3. Scoreboard: issue_rd=7 at cycle 0 gives pending=0x80 after the edge. A mem writeback with rd=7 is granted at cycle 2, write_select=7 at cycle 3, and pending returns to 0 after the edge at the end of cycle 3.
4. Simultaneous set/clear: with write_select=9 committing on the same edge that issue_rd=9 is issued, pending[9] remains 1.
5. Zero register:
   - issue_rd=0 leaves pending=0.
   - alu_valid with alu_rd=0 gives alu_ready=1, and next cycle write_select=0.
6. Reset mid-operation: rst=1 while mem is valid with rd=12, data=0x1234.
   - mem_ready=0.
   - After reset write_select=0 and pending=0, and no write of 0x1234 ever reaches the register file.
